// File: rtl/mdio_sched_if.sv
// Bundles the host request/ack bus and the MDIO engine control bus of mdio_sched.
// slave = the scheduler's view; master = whoever drives the host and engine sides.
interface mdio_sched_if;
  // Host side
  logic        req;
  logic        req_rw;
  logic [4:0]  req_phy;
  logic [4:0]  req_reg;
  logic [15:0] req_wdata;
  logic        ack;
  logic [15:0] rdata;
  logic        busy;
  logic        link_up;
  logic        link_chg;
  // Engine side
  logic        m_start;
  logic        m_rw;
  logic [4:0]  m_phy;
  logic [4:0]  m_reg;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        m_done;

  modport slave (
    input  req, req_rw, req_phy, req_reg, req_wdata, m_rdata, m_done,
    output ack, rdata, busy, link_up, link_chg,
           m_start, m_rw, m_phy, m_reg, m_wdata
  );

  modport master (
    output req, req_rw, req_phy, req_reg, req_wdata, m_rdata, m_done,
    input  ack, rdata, busy, link_up, link_chg,
           m_start, m_rw, m_phy, m_reg, m_wdata
  );
endinterface

// File: rtl/mdio_sched.sv
// MDIO scheduler: serialises host PHY register requests with a periodic link poll.
// Define MDIO_SCHED_POLL_EN to build the poll timer, POLL state and link_up/link_chg.
module mdio_sched #(
  parameter logic [15:0] POLL_DIV = 16'd50000,
  parameter logic [4:0]  POLL_PHY = 5'd1,
  parameter logic [4:0]  POLL_REG = 5'd1,
  parameter int          LINK_BIT = 2
) (
  input  logic        mdc,
  input  logic        rst,
  mdio_sched_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_HOST, S_POLL, S_GAP} state_e;

  state_e      state_q;
  logic        m_start_q;
  logic        m_rw_q;
  logic [4:0]  m_phy_q;
  logic [4:0]  m_reg_q;
  logic [15:0] m_wdata_q;
  logic [15:0] rdata_q;
  logic        ack_q;
  logic        busy_q;

`ifdef MDIO_SCHED_POLL_EN
  logic [15:0] poll_cnt_q;
  logic [15:0] poll_cnt_d;
  logic        poll_exp;
  logic        poll_pend_q;
  logic        link_up_q;
  logic        link_chg_q;
  logic        link_new;

  always_comb begin
    // NOTE: every always_comb output is given a default first so no latch is inferred.
    poll_exp   = (poll_cnt_q == 16'd0);
    poll_cnt_d = poll_cnt_q - 16'd1;
    if (poll_exp) begin
      poll_cnt_d = POLL_DIV - 16'd1;
    end
  end

  assign link_new = bus.m_rdata[LINK_BIT];

  always_ff @(posedge mdc) begin
    if (rst) begin
      poll_cnt_q <= POLL_DIV - 16'd1;
    end else begin
      poll_cnt_q <= poll_cnt_d;
    end
  end
`endif

  // NOTE: state registers use non-blocking assignments only, so every branch reads pre-edge values.
  always_ff @(posedge mdc) begin
    if (rst) begin
      state_q     <= S_IDLE;
      m_start_q   <= 1'b0;
      m_rw_q      <= 1'b0;
      m_phy_q     <= 5'd0;
      m_reg_q     <= 5'd0;
      m_wdata_q   <= 16'd0;
      rdata_q     <= 16'd0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MDIO_SCHED_POLL_EN
      poll_pend_q <= 1'b0;
      link_up_q   <= 1'b0;
      link_chg_q  <= 1'b0;
`endif
    end else begin
      ack_q      <= 1'b0;
`ifdef MDIO_SCHED_POLL_EN
      link_chg_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            m_rw_q    <= bus.req_rw;
            m_phy_q   <= bus.req_phy;
            m_reg_q   <= bus.req_reg;
            m_wdata_q <= bus.req_wdata;
            m_start_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_HOST;
          end
`ifdef MDIO_SCHED_POLL_EN
          else if (poll_pend_q) begin
            m_rw_q      <= 1'b0;
            m_phy_q     <= POLL_PHY;
            m_reg_q     <= POLL_REG;
            m_start_q   <= 1'b1;
            poll_pend_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_POLL;
          end
`endif
        end
        S_HOST: begin
          if (bus.m_done) begin
            m_start_q <= 1'b0;
            ack_q     <= 1'b1;
            if (!m_rw_q) begin
              rdata_q <= bus.m_rdata;
            end
            state_q   <= S_GAP;
          end
        end
`ifdef MDIO_SCHED_POLL_EN
        S_POLL: begin
          if (bus.m_done) begin
            m_start_q  <= 1'b0;
            link_up_q  <= link_new;
            link_chg_q <= (link_new != link_up_q);
            state_q    <= S_GAP;
          end
        end
`endif
        S_GAP: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          m_start_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
`ifdef MDIO_SCHED_POLL_EN
      // Placed after the case so an expiry on the launch edge stays pending.
      if (poll_exp) begin
        poll_pend_q <= 1'b1;
      end
`endif
    end
  end

  assign bus.m_start = m_start_q;
  assign bus.m_rw    = m_rw_q;
  assign bus.m_phy   = m_phy_q;
  assign bus.m_reg   = m_reg_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.rdata   = rdata_q;
  assign bus.ack     = ack_q;
  assign bus.busy    = busy_q;
`ifdef MDIO_SCHED_POLL_EN
  assign bus.link_up  = link_up_q;
  assign bus.link_chg = link_chg_q;
`else
  assign bus.link_up  = 1'b0;
  assign bus.link_chg = 1'b0;
`endif

endmodule

// File: tb/tb_mdio_sched.sv
// Bench for mdio_sched: engine model, transaction-level reference model checked every
// cycle, and directed host/poll/contention/reset scenarios with literal expectations.
module tb_mdio_sched;

  localparam logic [15:0] POLL_DIV = 16'd100;
  localparam logic [4:0]  POLL_PHY = 5'd1;
  localparam logic [4:0]  POLL_REG = 5'd1;
  localparam int          LINK_BIT = 2;
`ifdef MDIO_SCHED_POLL_EN
  localparam bit POLL_ON = 1'b1;
`else
  localparam bit POLL_ON = 1'b0;
`endif

  logic mdc;
  logic rst;
  logic [15:0] eng_rdata;
  int eng_cnt;

  mdio_sched_if bus ();

  mdio_sched #(
    .POLL_DIV(POLL_DIV),
    .POLL_PHY(POLL_PHY),
    .POLL_REG(POLL_REG),
    .LINK_BIT(LINK_BIT)
  ) dut (
    .mdc(mdc),
    .rst(rst),
    .bus(bus)
  );

  assign bus.m_rdata = eng_rdata;

  initial begin
    mdc = 1'b0;
    forever #5 mdc = ~mdc;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Engine: m_done is high during the cycle following the 33rd edge after m_start rose.
  initial begin
    eng_cnt = 0;
    bus.m_done = 1'b0;
    forever begin
      @(negedge mdc);
      if (bus.m_start === 1'b1) eng_cnt++;
      else eng_cnt = 0;
      bus.m_done = (eng_cnt == 34);
    end
  end

  // Reference model: a transaction is a 34-edge span from grant to completion,
  // followed by one gap edge; polls fall due every POLL_DIV edges after reset.
  int          m_phase;   // -1 idle, 0..33 engine running, 34 gap
  bit          m_host;
  bit          m_pend;
  int          m_k;
  bit          model_ok;
  logic        e_start, e_rw, e_ack, e_link, e_chg;
  logic [4:0]  e_phy, e_reg;
  logic [15:0] e_wdata, e_rdata;

  // Monitors feeding the directed checks
  int   cyc;
  int   n_host, n_poll, n_ack, n_chg;
  int   last_host_start, last_poll_start, last_ack, prev_start, start_period;
  logic prev_m_start;

  initial begin
    bit expire;
    bit launch;
    model_ok = 0; cyc = 0; m_phase = -1; m_pend = 0; m_k = 0; m_host = 0;
    n_host = 0; n_poll = 0; n_ack = 0; n_chg = 0;
    last_host_start = 0; last_poll_start = 0; last_ack = 0; prev_start = 0; start_period = 0;
    prev_m_start = 1'b0;
    forever begin
      @(posedge mdc);
      #1;
      cyc++;
      if (rst === 1'b1) begin
        model_ok = 1; m_phase = -1; m_pend = 0; m_k = 0;
        e_start = 0; e_rw = 0; e_ack = 0; e_link = 0; e_chg = 0;
        e_phy = 0; e_reg = 0; e_wdata = 0; e_rdata = 0;
      end else if (model_ok) begin
        m_k++;
        expire = POLL_ON && (m_k % int'(POLL_DIV) == 0);
        launch = 0;
        e_ack = 0;
        e_chg = 0;
        if (m_phase == -1) begin
          if (bus.req === 1'b1) begin
            m_host = 1; m_phase = 0; e_start = 1;
            e_rw = bus.req_rw; e_phy = bus.req_phy; e_reg = bus.req_reg; e_wdata = bus.req_wdata;
          end else if (m_pend) begin
            m_host = 0; m_phase = 0; e_start = 1; launch = 1;
            e_rw = 0; e_phy = POLL_PHY; e_reg = POLL_REG;
          end
        end else if (m_phase < 33) begin
          m_phase++;
        end else if (m_phase == 33) begin
          m_phase = 34;
          e_start = 0;
          if (m_host) begin
            e_ack = 1;
            if (!e_rw) e_rdata = eng_rdata;
          end else begin
            e_chg = (eng_rdata[LINK_BIT] != e_link);
            e_link = eng_rdata[LINK_BIT];
          end
        end else begin
          m_phase = -1;
        end
        if (expire) m_pend = 1;
        else if (launch) m_pend = 0;
      end

      if (model_ok) begin
        check("m_start", bus.m_start, e_start);
        check("m_rw", bus.m_rw, e_rw);
        check("m_phy", bus.m_phy, e_phy);
        check("m_reg", bus.m_reg, e_reg);
        check("m_wdata", bus.m_wdata, e_wdata);
        check("ack", bus.ack, e_ack);
        check("rdata", bus.rdata, e_rdata);
        check("busy", bus.busy, (m_phase != -1));
        check("link_up", bus.link_up, e_link);
        check("link_chg", bus.link_chg, e_chg);
      end

      if (bus.m_start === 1'b1 && prev_m_start !== 1'b1) begin
        if (bus.m_rw === 1'b0 && bus.m_phy === POLL_PHY && bus.m_reg === POLL_REG) begin
          n_poll++; last_poll_start = cyc;
        end else begin
          n_host++; last_host_start = cyc;
        end
        start_period = cyc - prev_start;
        prev_start = cyc;
      end
      prev_m_start = bus.m_start;
      if (bus.ack === 1'b1) begin n_ack++; last_ack = cyc; end
      if (bus.link_chg === 1'b1) n_chg++;
    end
  end

  // Call at a falling edge: raises req now, returns at the falling edge where ack is seen
  // with req dropped. lat = edges from the req-sampling edge to the ack edge.
  task automatic host_txn(input logic rw, input logic [4:0] phy, input logic [4:0] reg_a,
                          input logic [15:0] wd, output int lat);
    bus.req = 1'b1; bus.req_rw = rw; bus.req_phy = phy; bus.req_reg = reg_a; bus.req_wdata = wd;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge mdc);
      lat++;
      if (bus.ack === 1'b1) break;
    end
    check("ack_seen", bus.ack, 1'b1);
    bus.req = 1'b0;
  endtask

  task automatic wait_poll(input int base, input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge mdc);
      if (n_poll > base) break;
    end
    check(name, n_poll, base + 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int lat, base, na, nc, hp, ns;
    rst = 1'b1;
    eng_rdata = 16'h0000;
    bus.req = 1'b0; bus.req_rw = 1'b0; bus.req_phy = 5'd0; bus.req_reg = 5'd0; bus.req_wdata = 16'd0;
    repeat (3) @(negedge mdc);
    rst = 1'b0;
    check("rst_m_start", bus.m_start, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_rdata", bus.rdata, 16'h0000);
    check("rst_link_up", bus.link_up, 1'b0);

    // Host write; engine data present on m_rdata must not reach rdata
    eng_rdata = 16'hBEEF;
    @(negedge mdc);
    host_txn(1'b1, 5'd1, 5'd0, 16'h1140, lat);
    check("wr_latency", lat, 34);
    check("wr_rdata_kept", bus.rdata, 16'h0000);
    check("wr_wdata_held", bus.m_wdata, 16'h1140);

    // Host read, back to back with the write
    eng_rdata = 16'h796D;
    @(negedge mdc);
    host_txn(1'b0, 5'd1, 5'd2, 16'h0000, lat);
    check("rd_latency", lat, 34);
    check("rd_rdata", bus.rdata, 16'h796D);
    check("b2b_period", start_period, 36);
    repeat (2) @(negedge mdc);
    check("rd_busy_low", bus.busy, 1'b0);

    if (POLL_ON) begin
      // First poll raises the link
      eng_rdata = 16'h0004;
      base = n_poll;
      wait_poll(base, "poll1_start");
      repeat (40) @(negedge mdc);
      check("poll1_link_up", bus.link_up, 1'b1);
      check("poll1_chg_count", n_chg, 1);

      // Same value again: no change pulse
      base = n_poll;
      wait_poll(base, "poll2_start");
      repeat (40) @(negedge mdc);
      check("poll2_link_up", bus.link_up, 1'b1);
      check("poll2_chg_count", n_chg, 1);

      // Host request on the very edge the timer expires
      eng_rdata = 16'h0000;
      for (int i = 0; i < 300; i++) begin
        @(negedge mdc);
        if (bus.busy === 1'b0 && !m_pend && ((m_k + 1) % int'(POLL_DIV) == 0)) break;
      end
      hp = n_poll;
      host_txn(1'b0, 5'd1, 5'd3, 16'h0000, lat);
      check("cont_latency", lat, 34);
      check("cont_rdata", bus.rdata, 16'h0000);
      repeat (40) @(negedge mdc);
      check("cont_one_poll", n_poll, hp + 1);
      check("cont_host_first", (last_poll_start > last_host_start), 1'b1);
      check("cont_poll_gap", last_poll_start - last_ack, 2);
      check("cont_link_down", bus.link_up, 1'b0);
      check("cont_chg_count", n_chg, 2);
    end else begin
      ns = n_host + n_poll;
      repeat (10000) @(negedge mdc);
      check("idle_no_start", n_host + n_poll, ns);
      check("idle_link_up", bus.link_up, 1'b0);
    end

    // Reset at engine cycle 20
    na = n_ack;
    nc = n_chg;
    @(negedge mdc);
    bus.req = 1'b1; bus.req_rw = 1'b0; bus.req_phy = 5'd1; bus.req_reg = 5'd4; bus.req_wdata = 16'd0;
    for (int i = 0; i < 100; i++) begin
      @(negedge mdc);
      #1;
      if (eng_cnt == 20) break;
    end
    check("rst_engine_cycle", eng_cnt, 20);
    rst = 1'b1;
    bus.req = 1'b0;
    @(negedge mdc);
    check("midrst_m_start", bus.m_start, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_ack", bus.ack, 1'b0);
    rst = 1'b0;
    repeat (40) @(negedge mdc);
    check("midrst_no_ack", n_ack, na);
    check("midrst_no_chg", n_chg, nc);

    // A later request completes normally
    @(negedge mdc);
    host_txn(1'b1, 5'd2, 5'd5, 16'hA5A5, lat);
    check("post_rst_latency", lat, 34);
    check("post_rst_ack_count", n_ack, na + 1);
    repeat (4) @(negedge mdc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
